// File: rtl/axi4_frame_reader.sv
// ----------------------------------------------------------------------------
// axi4_frame_reader
// AXI4 read master that streams a stored video frame out of DDR. Each frame
// is fetched as BURSTS_PER_FRAME fixed-length INCR bursts of BURST_BEATS
// beats, starting at FRAME_BASE_ADDR. Every accepted beat is passed straight
// through to the display-side valid/ready stream. At most one burst is in
// flight at any time.
//
// Ports
//   clk_100Mhz, rst       : clock, synchronous active-high reset
//   enable, frame_start   : fetch enable (level) and frame restart (pulse)
//   space_ok              : downstream can take a full burst
//   AR* / R*              : AXI4 read address and read data channels
//   out_data/valid/ready  : downstream pixel-word stream
//   frame_end             : one-cycle pulse after the last beat of a frame
//   rd_error              : sticky error (bad RRESP or RLAST misplacement)
//   state                 : FSM state for debug (0 idle, 1 addr, 2 data)
// ----------------------------------------------------------------------------
module axi4_frame_reader #(
    parameter int unsigned                 AXI_ADDR_WIDTH   = 32,
    parameter int unsigned                 AXI_DATA_WIDTH   = 64,
    parameter logic [AXI_ADDR_WIDTH-1:0]   FRAME_BASE_ADDR  = 32'h0100_0000,
    parameter int unsigned                 BURST_BEATS      = 64,
    parameter int unsigned                 BURSTS_PER_FRAME = 300
) (
    input  logic                      clk_100Mhz,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      frame_start,
    input  logic                      space_ok,
    output logic [AXI_ADDR_WIDTH-1:0] ARADDR,
    output logic                      ARVALID,
    input  logic                      ARREADY,
    output logic [7:0]                ARLEN,
    output logic [2:0]                ARSIZE,
    output logic [1:0]                ARBURST,
    output logic [3:0]                ARCACHE,
    output logic [2:0]                ARPROT,
    input  logic [AXI_DATA_WIDTH-1:0] RDATA,
    input  logic                      RVALID,
    output logic                      RREADY,
    input  logic                      RLAST,
    input  logic [1:0]                RRESP,
    output logic [AXI_DATA_WIDTH-1:0] out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      frame_end,
    output logic                      rd_error,
    output logic [1:0]                state
);

    localparam int unsigned BEAT_W  = $clog2(BURST_BEATS);
    localparam int unsigned BURST_W = $clog2(BURSTS_PER_FRAME);

    localparam logic [BEAT_W-1:0]         LAST_BEAT   = BEAT_W'(BURST_BEATS - 1);
    localparam logic [BURST_W-1:0]        LAST_BURST  = BURST_W'(BURSTS_PER_FRAME - 1);
    localparam logic [AXI_ADDR_WIDTH-1:0] BURST_BYTES =
        AXI_ADDR_WIDTH'(BURST_BEATS * (AXI_DATA_WIDTH / 8));

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ADDR_SEND = 2'd1,
        ST_DATA_RECV = 2'd2
    } state_t;

    state_t                      r_state,       w_state_nxt;
    logic [AXI_ADDR_WIDTH-1:0]   r_araddr,      w_araddr_nxt;
    logic                        r_arvalid,     w_arvalid_nxt;
    logic [AXI_ADDR_WIDTH-1:0]   r_offset,      w_offset_nxt;
    logic [BEAT_W-1:0]           r_beat_cnt,    w_beat_cnt_nxt;
    logic [BURST_W-1:0]          r_burst_cnt,   w_burst_cnt_nxt;
    logic                        r_frame_end,   w_frame_end_nxt;
    logic                        r_rd_error,    w_rd_error_nxt;
    logic                        r_restart,     w_restart_nxt;
    logic [AXI_ADDR_WIDTH-1:0]   w_idle_offset;
    logic                        w_beat_acc;

    // Fixed burst shape: full-width beats, incrementing, non-cacheable data.
    assign ARLEN   = 8'(BURST_BEATS - 1);
    assign ARSIZE  = 3'b011;
    assign ARBURST = 2'b01;
    assign ARCACHE = 4'b0000;
    assign ARPROT  = 3'b010;

    assign ARADDR    = r_araddr;
    assign ARVALID   = r_arvalid;
    assign frame_end = r_frame_end;
    assign rd_error  = r_rd_error;
    assign state     = r_state;

    // Zero-latency data path: the stream is only live while receiving a burst.
    assign out_data   = RDATA;
    assign out_valid  = (r_state == ST_DATA_RECV) && RVALID;
    assign RREADY     = (r_state == ST_DATA_RECV) && out_ready;
    assign w_beat_acc = (r_state == ST_DATA_RECV) && RVALID && out_ready;

    // Next-state and datapath update for the burst sequencer.
    always_comb begin
        w_state_nxt     = r_state;
        w_araddr_nxt    = r_araddr;
        w_arvalid_nxt   = r_arvalid;
        w_offset_nxt    = r_offset;
        w_beat_cnt_nxt  = r_beat_cnt;
        w_burst_cnt_nxt = r_burst_cnt;
        w_frame_end_nxt = 1'b0;
        w_rd_error_nxt  = r_rd_error;
        w_restart_nxt   = r_restart;
        w_idle_offset   = r_offset;

        case (r_state)
            ST_IDLE: begin
                // A restart (pending or arriving now) rewinds before any new
                // address is formed, so the next burst starts at the base.
                if (r_restart || frame_start) begin
                    w_idle_offset   = '0;
                    w_offset_nxt    = '0;
                    w_burst_cnt_nxt = '0;
                    w_restart_nxt   = 1'b0;
                end else begin
                    w_idle_offset   = r_offset;
                end
                if (enable && space_ok) begin
                    w_araddr_nxt  = FRAME_BASE_ADDR + w_idle_offset;
                    w_arvalid_nxt = 1'b1;
                    w_state_nxt   = ST_ADDR_SEND;
                end else begin
                    w_state_nxt   = ST_IDLE;
                end
            end

            ST_ADDR_SEND: begin
                if (frame_start) begin
                    w_restart_nxt = 1'b1;
                end else begin
                    w_restart_nxt = r_restart;
                end
                if (r_arvalid && ARREADY) begin
                    w_arvalid_nxt  = 1'b0;
                    w_beat_cnt_nxt = '0;
                    w_state_nxt    = ST_DATA_RECV;
                end else begin
                    w_state_nxt    = ST_ADDR_SEND;
                end
            end

            ST_DATA_RECV: begin
                if (frame_start) begin
                    w_restart_nxt = 1'b1;
                end else begin
                    w_restart_nxt = r_restart;
                end
                if (w_beat_acc) begin
                    w_beat_cnt_nxt = r_beat_cnt + 1'b1;
                    // Burst length is governed by the count; RLAST is only
                    // cross-checked against it.
                    if ((RRESP != 2'b00) || (RLAST != (r_beat_cnt == LAST_BEAT))) begin
                        w_rd_error_nxt = 1'b1;
                    end else begin
                        w_rd_error_nxt = r_rd_error;
                    end
                    if (r_beat_cnt == LAST_BEAT) begin
                        w_state_nxt = ST_IDLE;
                        if (r_burst_cnt == LAST_BURST) begin
                            w_offset_nxt    = '0;
                            w_burst_cnt_nxt = '0;
                            w_frame_end_nxt = 1'b1;
                        end else begin
                            w_offset_nxt    = r_offset + BURST_BYTES;
                            w_burst_cnt_nxt = r_burst_cnt + 1'b1;
                        end
                    end else begin
                        w_state_nxt = ST_DATA_RECV;
                    end
                end else begin
                    w_state_nxt = ST_DATA_RECV;
                end
            end

            default: begin
                w_state_nxt   = ST_IDLE;
                w_arvalid_nxt = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_100Mhz) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_araddr    <= FRAME_BASE_ADDR;
            r_arvalid   <= 1'b0;
            r_offset    <= '0;
            r_beat_cnt  <= '0;
            r_burst_cnt <= '0;
            r_frame_end <= 1'b0;
            r_rd_error  <= 1'b0;
            r_restart   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_araddr    <= w_araddr_nxt;
            r_arvalid   <= w_arvalid_nxt;
            r_offset    <= w_offset_nxt;
            r_beat_cnt  <= w_beat_cnt_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
            r_frame_end <= w_frame_end_nxt;
            r_rd_error  <= w_rd_error_nxt;
            r_restart   <= w_restart_nxt;
        end
    end

endmodule

// File: tb/tb_axi4_frame_reader.sv
// ----------------------------------------------------------------------------
// tb_axi4_frame_reader
// Randomized bench for axi4_frame_reader. A small AXI slave returns random
// beats; a burst-level reference model predicts burst addresses, stream
// handshakes, frame_end and rd_error, and is compared against the DUT on
// every cycle. Literal expectations pin key addresses and counts.
// ----------------------------------------------------------------------------
module tb_axi4_frame_reader;

    localparam logic [31:0] BASE = 32'h0100_0000;

    logic        clk_100Mhz = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        frame_start = 1'b0;
    logic        space_ok = 1'b1;
    logic [31:0] ARADDR;
    logic        ARVALID;
    logic        ARREADY = 1'b0;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic [3:0]  ARCACHE;
    logic [2:0]  ARPROT;
    logic [63:0] RDATA = 64'd0;
    logic        RVALID = 1'b0;
    logic        RREADY;
    logic        RLAST = 1'b0;
    logic [1:0]  RRESP = 2'b00;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        frame_end;
    logic        rd_error;
    logic [1:0]  state;

    axi4_frame_reader dut (
        .clk_100Mhz (clk_100Mhz), .rst (rst), .enable (enable),
        .frame_start(frame_start), .space_ok (space_ok),
        .ARADDR (ARADDR), .ARVALID (ARVALID), .ARREADY (ARREADY),
        .ARLEN (ARLEN), .ARSIZE (ARSIZE), .ARBURST (ARBURST),
        .ARCACHE (ARCACHE), .ARPROT (ARPROT),
        .RDATA (RDATA), .RVALID (RVALID), .RREADY (RREADY),
        .RLAST (RLAST), .RRESP (RRESP),
        .out_data (out_data), .out_valid (out_valid), .out_ready (out_ready),
        .frame_end (frame_end), .rd_error (rd_error), .state (state)
    );

    always #5 clk_100Mhz = ~clk_100Mhz;

    int total = 0;
    int bad   = 0;

    // stimulus controls
    int ar_mode   = 1;   // 0 hold low, 1 always high, 2 random
    int or_mode   = 0;   // 0 always high, 1 toggle, 2 random
    bit rv_rand   = 1'b0;
    bit fs_arm    = 1'b0;
    int rlast_pos = 63;
    int rresp_pos = -1;

    // slave state
    logic [63:0] beat_data [64];
    bit s_active = 1'b0;
    int s_idx    = 0;
    bit hs_ar_seen = 1'b0;
    bit hs_r_seen  = 1'b0;

    // reference model
    bit          m_phase   = 1'b0;
    int          m_beats   = 0;
    int          m_k       = 0;
    int          m_cur     = 0;
    bit          m_restart = 1'b0;
    bit          m_fe      = 1'b0;
    bit          m_err     = 1'b0;
    bit          p_wait    = 1'b0;
    logic [31:0] p_addr    = 32'd0;
    logic [31:0] ar_log [512];
    int          ar_count    = 0;
    int          bursts_done = 0;
    int          fe_count    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the burst-level model, then model update.
    always @(negedge clk_100Mhz) begin
        if (rst) begin
            m_phase = 1'b0; m_beats = 0; m_k = 0; m_cur = 0; m_restart = 1'b0;
            m_fe = 1'b0; m_err = 1'b0; p_wait = 1'b0;
            hs_ar_seen = 1'b0; hs_r_seen = 1'b0;
        end else begin
            bit acc;
            int idx;
            acc = m_phase && RVALID && out_ready;
            chk("out_valid", 64'(out_valid), 64'(m_phase && RVALID));
            chk("rready", 64'(RREADY), 64'(m_phase && out_ready));
            chk("frame_end", 64'(frame_end), 64'(m_fe));
            chk("rd_error", 64'(rd_error), 64'(m_err));
            if (m_phase) begin
                chk("arvalid_in_data", 64'(ARVALID), 64'd0);
                chk("state_data", 64'(state), 64'd2);
            end
            if (p_wait) begin
                chk("arvalid_hold", 64'(ARVALID), 64'd1);
                chk("araddr_hold", 64'(ARADDR), 64'(p_addr));
            end
            if (out_valid) chk("out_data_pass", out_data, RDATA);
            if (acc) chk("beat_order", out_data, beat_data[m_beats]);
            if (frame_end) fe_count++;

            m_fe = 1'b0;
            if (ARVALID && ARREADY && !m_phase) begin
                idx = m_restart ? 0 : m_k;
                chk("araddr", 64'(ARADDR), 64'(BASE + 32'(idx * 512)));
                if (ar_count < 512) ar_log[ar_count] = ARADDR;
                ar_count++;
                m_cur = idx; m_restart = 1'b0; m_phase = 1'b1; m_beats = 0;
            end else if (acc) begin
                if (RRESP != 2'b00 || RLAST != (m_beats == 63)) m_err = 1'b1;
                m_beats++;
                if (m_beats == 64) begin
                    m_phase = 1'b0;
                    m_fe = (m_cur == 299);
                    m_k = (m_cur == 299) ? 0 : m_cur + 1;
                    bursts_done++;
                end
            end
            if (frame_start) m_restart = 1'b1;
            p_wait     = ARVALID && !ARREADY;
            p_addr     = ARADDR;
            hs_ar_seen = ARVALID && ARREADY;
            hs_r_seen  = RVALID && RREADY;
        end
    end

    // One clock of stimulus: AXI slave behaviour plus downstream ready.
    task automatic step();
        @(posedge clk_100Mhz);
        #1;
        frame_start = 1'b0;
        if (fs_arm && m_phase && m_cur == 5 && m_beats == 20) begin
            frame_start = 1'b1;
            fs_arm = 1'b0;
        end
        case (ar_mode)
            0:       ARREADY = 1'b0;
            1:       ARREADY = 1'b1;
            default: ARREADY = 1'($urandom_range(0, 1));
        endcase
        case (or_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = !out_ready;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
        if (hs_r_seen) s_idx++;
        if (s_idx >= 64) s_active = 1'b0;
        if (hs_ar_seen) begin
            s_active = 1'b1;
            s_idx = 0;
            for (int i = 0; i < 64; i++) beat_data[i] = {$urandom, $urandom};
        end
        if (s_active) begin
            if (!(RVALID && !hs_r_seen)) RVALID = rv_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            RDATA = beat_data[s_idx];
            RLAST = (s_idx == rlast_pos);
            RRESP = (s_idx == rresp_pos) ? 2'b10 : 2'b00;
        end else begin
            RVALID = 1'b0;
            RLAST  = 1'b0;
            RRESP  = 2'b00;
            RDATA  = {$urandom, $urandom};
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(state == 2'd0 && !ARVALID && !m_phase) && n < 3000) begin step(); n++; end
        chk("idle_timeout", 64'(n < 3000), 64'd1);
    endtask

    task automatic wait_bursts(input int target, input int limit);
        int n = 0;
        while (bursts_done < target && n < limit) begin step(); n++; end
        chk("burst_timeout", 64'(n < limit), 64'd1);
    endtask

    initial begin
        int n;
        int base_ix;
        int fe0;
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("rst_arvalid", 64'(ARVALID), 64'd0);
        chk("rst_araddr", 64'(ARADDR), 64'(BASE));
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_frame_end", 64'(frame_end), 64'd0);
        chk("rst_rd_error", 64'(rd_error), 64'd0);
        chk("arlen", 64'(ARLEN), 64'd63);
        chk("arsize_burst", 64'({ARSIZE, ARBURST, ARCACHE, ARPROT}), 64'({3'b011, 2'b01, 4'b0000, 3'b010}));

        // Full frame with a always-ready slave and sink.
        enable = 1'b1;
        n = 0;
        while (ar_count < 301 && n < 25000) begin step(); n++; end
        chk("frame_timeout", 64'(n < 25000), 64'd1);
        chk("addr_burst1", 64'(ar_log[1]), 64'h0100_0200);
        chk("addr_burst299", 64'(ar_log[299]), 64'h0102_5600);
        chk("addr_wrap", 64'(ar_log[300]), 64'h0100_0000);
        chk("frame_end_count", 64'(fe_count), 64'd1);

        // ARREADY held low: address must stay stable.
        ar_mode = 0;
        n = 0;
        while (!ARVALID && n < 300) begin step(); n++; end
        chk("arvalid_timeout", 64'(n < 300), 64'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_arvalid", 64'(ARVALID), 64'd1);
            chk("stall_state", 64'(state), 64'd1);
            chk("stall_araddr", 64'(ARADDR), 64'h0100_0200);
        end
        ar_mode = 1;

        // Toggling sink ready and random slave valid.
        or_mode = 1;
        rv_rand = 1'b1;
        ar_mode = 2;
        wait_bursts(bursts_done + 2, 2000);

        // Restart while idle, then restart mid-burst 5.
        or_mode = 2;
        enable = 1'b0;
        wait_idle();
        step();
        frame_start = 1'b1;
        step();
        fe0 = fe_count;
        base_ix = ar_count;
        enable = 1'b1;
        fs_arm = 1'b1;
        n = 0;
        while (ar_count < base_ix + 7 && n < 6000) begin step(); n++; end
        chk("restart_timeout", 64'(n < 6000), 64'd1);
        chk("restart_first", 64'(ar_log[base_ix]), 64'h0100_0000);
        chk("burst5_addr", 64'(ar_log[base_ix + 5]), 64'h0100_0A00);
        chk("after_restart", 64'(ar_log[base_ix + 6]), 64'h0100_0000);
        chk("no_frame_end", 64'(fe_count), 64'(fe0));
        chk("fs_fired", 64'(fs_arm), 64'd0);

        // space_ok gating in idle.
        enable = 1'b0;
        wait_idle();
        space_ok = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("space_block", 64'(ARVALID), 64'd0);
        end
        space_ok = 1'b1;
        step();
        chk("space_go", 64'(ARVALID), 64'd1);

        // Error response and early RLAST: sticky error, burst still 64 beats.
        chk("err_before", 64'(rd_error), 64'd0);
        rresp_pos = 2;
        rlast_pos = 39;
        wait_bursts(bursts_done + 1, 2000);
        rresp_pos = -1;
        rlast_pos = 63;
        step();
        chk("err_set", 64'(rd_error), 64'd1);
        wait_bursts(bursts_done + 1, 2000);
        chk("err_sticky", 64'(rd_error), 64'd1);

        enable = 1'b0;
        repeat (10) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
